demux_one_hot_pipe: RTL

- One-hot demultiplexer: the write-side counterpart of the one-hot word mux. Steers each input word to the output channel named by a one-hot select.
- Input is a valid/ready stream; each of WORD_COUNT output channels has its own 2-entry buffer and valid/ready handshake.
- Output words are packed into a flat bus, in the same layout as the mux's flat input.
- Sits between a single producer and multiple per-lane consumers. Words with an invalid select are dropped and counted.

---
 rtl/demux_one_hot_pipe_pkg.sv | 26 ++
 rtl/demux_one_hot_pipe_chan_buf2.sv | 76 +++++++
 rtl/demux_one_hot_pipe.sv | 74 +++++++
 3 files changed

// File: rtl/demux_one_hot_pipe_pkg.sv
// Shared types and helpers for the one-hot demultiplexer and its companion mux.
// Holds the occupancy encoding, the one-hot test and the saturating increment.
package demux_one_hot_pipe_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   // Widest select and counter the helpers accept; callers zero-extend into these.
   localparam int unsigned MAX_SEL_WIDTH = 64;
   localparam int unsigned MAX_CNT_WIDTH = 32;

   function automatic logic is_one_hot(input logic [MAX_SEL_WIDTH-1:0] v);
      return (v != '0) && ((v & (v - 64'd1)) == '0);
   endfunction

   function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(input logic [MAX_CNT_WIDTH-1:0] v,
                                                       input int unsigned width);
      logic [MAX_CNT_WIDTH-1:0] max_val;
      max_val = (width >= MAX_CNT_WIDTH) ? '1 : ((32'd1 << width) - 32'd1);
      return (v >= max_val) ? max_val : v + 32'd1;
   endfunction

endpackage

// File: rtl/demux_one_hot_pipe_chan_buf2.sv
// Two-entry per-channel output buffer with push/pop handshake and occupancy state.
// The head register is cleared whenever the buffer drains so an empty channel reads as zero.
module demux_chan_buf2
   import demux_one_hot_pipe_pkg::*;
#(
   parameter int WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WORD_WIDTH-1:0] din,
   output logic                  valid,
   output logic                  full,
   output logic [WORD_WIDTH-1:0] head
);

   occ_t                  occ_reg,  occ_next;
   logic [WORD_WIDTH-1:0] head_reg, head_next;
   logic [WORD_WIDTH-1:0] tail_reg, tail_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_reg  <= OCC_EMPTY;
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         occ_reg  <= occ_next;
         head_reg <= head_next;
         tail_reg <= tail_next;
      end
   end

   always_comb begin
      occ_next  = occ_reg;
      head_next = head_reg;
      tail_next = tail_reg;
      case (occ_reg)
         OCC_EMPTY: begin
            if (push) begin
               occ_next  = OCC_ONE;
               head_next = din;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               head_next = din;
            end else if (push) begin
               occ_next  = OCC_TWO;
               tail_next = din;
            end else if (pop) begin
               occ_next  = OCC_EMPTY;
               head_next = '0;
            end
         end
         OCC_TWO: begin
            // The top holds ready low for a full channel, so push never arrives here.
            if (pop) begin
               occ_next  = OCC_ONE;
               head_next = tail_reg;
               tail_next = '0;
            end
         end
         default: begin
            occ_next  = OCC_EMPTY;
            head_next = '0;
            tail_next = '0;
         end
      endcase
   end

   assign valid = (occ_reg != OCC_EMPTY);
   assign full  = (occ_reg == OCC_TWO);
   assign head  = head_reg;

endmodule

// File: rtl/demux_one_hot_pipe.sv
// One-hot demultiplexer: steers each accepted word into the buffered channel named by IN_SEL.
// Words with a zero or multi-hot select are accepted, dropped and counted.
module demux_one_hot_pipe
   import demux_one_hot_pipe_pkg::*;
#(
   parameter  int WORD_WIDTH  = 8,
   parameter  int WORD_COUNT  = 4,
   parameter  int CNT_WIDTH   = 8,
   localparam int TOTAL_WIDTH = WORD_COUNT * WORD_WIDTH
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [WORD_COUNT-1:0]  IN_SEL,
   input  logic [WORD_WIDTH-1:0]  IN_DATA,
   output logic [WORD_COUNT-1:0]  OUT_VALID,
   input  logic [WORD_COUNT-1:0]  OUT_READY,
   output logic [TOTAL_WIDTH-1:0] WORDS_OUT,
   output logic                   SEL_ERROR,
   output logic [CNT_WIDTH-1:0]   DROP_COUNT
);

   logic                  sel_ok;
   logic                  accept;
   logic                  drop;
   logic [WORD_COUNT-1:0] full;
   logic [WORD_COUNT-1:0] push;
   logic                  sel_error_reg;
   logic [CNT_WIDTH-1:0]  drop_count_reg, drop_count_next;

   assign sel_ok = is_one_hot(MAX_SEL_WIDTH'(IN_SEL));

   // Ready looks only at registered fullness, never at OUT_READY, so a full
   // channel stays closed even in a cycle where it is also draining.
   assign IN_READY = sel_ok ? ~|(full & IN_SEL) : 1'b1;
   assign accept   = IN_VALID & IN_READY;
   assign drop     = accept & ~sel_ok;

   generate
      for (genvar gi = 0; gi < WORD_COUNT; gi++) begin : g_chan
         assign push[gi] = accept & sel_ok & IN_SEL[gi];

         demux_chan_buf2 #(
            .WORD_WIDTH (WORD_WIDTH)
         ) u_buf (
            .clk   (CLK),
            .rst   (RESET),
            .push  (push[gi]),
            .pop   (OUT_VALID[gi] & OUT_READY[gi]),
            .din   (IN_DATA),
            .valid (OUT_VALID[gi]),
            .full  (full[gi]),
            .head  (WORDS_OUT[WORD_WIDTH*gi +: WORD_WIDTH])
         );
      end
   endgenerate

   assign drop_count_next = CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(drop_count_reg), CNT_WIDTH));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sel_error_reg  <= 1'b0;
         drop_count_reg <= '0;
      end else if (drop) begin
         sel_error_reg  <= 1'b1;
         drop_count_reg <= drop_count_next;
      end
   end

   assign SEL_ERROR  = sel_error_reg;
   assign DROP_COUNT = drop_count_reg;

endmodule
